// File: rtl/intr_mode_fifo_if.sv
// rtl/intr_mode_fifo_if.sv - enqueue/dequeue handshake and status bundle for the interrupt mode queue
interface intr_mode_fifo_if #(
    parameter int MODE_W = 3,
    parameter int DEPTH  = 8
);
    logic                     enqueue;
    logic [MODE_W-1:0]        In_mode;
    logic                     dequeue;
    logic                     clr_ovf;
    logic                     Q;
    logic [MODE_W-1:0]        mode;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    // Interrupt sources / dispatch side drive requests and watch status
    modport master (
        output enqueue, In_mode, dequeue, clr_ovf,
        input  Q, mode, full, count, overflow
    );

    // The queue itself
    modport slave (
        input  enqueue, In_mode, dequeue, clr_ovf,
        output Q, mode, full, count, overflow
    );
endinterface

// File: rtl/intr_mode_fifo.sv
// rtl/intr_mode_fifo.sv - circular queue of pending interrupt mode codes with dedup and sticky overflow
module intr_mode_fifo #(
    parameter int MODE_W = 3,
    parameter int DEPTH  = 8,
    parameter int DEDUP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    intr_mode_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [MODE_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  head_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_q;
    logic              ovf_d;

    logic              not_empty;
    logic              deq_ok;
    logic              enq_cand;
    logic              dup_hit;
    logic              is_dup;
    logic              has_room;
    logic              enq_ok;
    logic              ovf_evt;
    logic [PTR_W-1:0]  wr_slot;
    logic [PTR_W-1:0]  scan_slot;

    assign not_empty = (count_q != '0);
    assign deq_ok    = bus.dequeue & not_empty;
    assign enq_cand  = bus.enqueue & (bus.In_mode != '0);
    // A full queue still accepts when the head leaves in the same cycle
    assign has_room  = (count_q != CNT_W'(DEPTH)) | deq_ok;
    // When count == DEPTH the low bits wrap to head, which is the slot being freed
    assign wr_slot   = head_q + count_q[PTR_W-1:0];

    // Scan valid entries for a pending copy of In_mode; a departing head does not count
    always_comb begin
        dup_hit   = 1'b0;
        scan_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_slot = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && !(deq_ok && (i == 0)) &&
                (entry_q[scan_slot] == bus.In_mode)) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign is_dup  = (DEDUP != 0) && dup_hit;
    assign enq_ok  = enq_cand & ~is_dup & has_room;
    assign ovf_evt = enq_cand & ~is_dup & ~has_room;

    // Next-state for head, count and the sticky flag (a new event beats clr_ovf)
    always_comb begin
        head_d  = deq_ok ? head_q + PTR_W'(1) : head_q;
        count_d = count_q + CNT_W'(enq_ok) - CNT_W'(deq_ok);
        ovf_d   = ovf_evt ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
    end

    // Register update; the enqueue write follows the head clear so it wins on a shared slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (deq_ok) begin
                entry_q[head_q] <= '0;
            end
            if (enq_ok) begin
                entry_q[wr_slot] <= bus.In_mode;
            end
            head_q  <= head_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Q        = not_empty;
    assign bus.mode     = not_empty ? entry_q[head_q] : '0;
    assign bus.full     = (count_q == CNT_W'(DEPTH));
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule
